// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add sequential multiplier with start/busy/done handshake.
// Operands are latched on an accepted start. Signed operands are converted to
// unsigned magnitudes. WIDTH add/shift iterations follow, and a final FIX
// cycle restores the sign of the product. Latency is WIDTH+2 cycles per result.
module seq_multiplier_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;   // multiplier, fills with product low half
    logic [WIDTH-1:0]     acc_q, acc_d;         // product high half
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   c_q, c_d;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   raw_s;

    // Unsigned magnitude of an operand. The most-negative value maps onto
    // 2^(WIDTH-1), which still fits the WIDTH-bit unsigned result.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Next-state and datapath: accept, one add/shift iteration per RUN cycle, sign fix.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        c_d      = c_q;

        addend_s = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
        sum_s    = {1'b0, acc_q} + {1'b0, addend_s};
        raw_s    = {acc_q, mplier_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = magnitude(A, is_signed);
                    mplier_d = magnitude(B, is_signed);
                    neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    acc_d    = {WIDTH{1'b0}};
                    count_d  = {CW{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                // Shift {carry, acc, mplier} right by one after the conditional add.
                acc_d    = sum_s[WIDTH:1];
                mplier_d = {sum_s[0], mplier_q[WIDTH-1:1]};
                count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
                if (count_d == CW'(WIDTH)) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end
            FIX: begin
                // Two's-complement negate; negating zero yields zero.
                if (neg_q) begin
                    c_d = ~raw_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    c_d = raw_s;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            count_q  <= {CW{1'b0}};
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= {(2*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_q      <= c_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign C    = c_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Self-checking bench for seq_multiplier_param (WIDTH=8 and WIDTH=16 instances),
// using directed cases plus random operands checked against an arithmetic model.
module tb_seq_multiplier_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, sg8, busy8, done8;
    logic [7:0]  A8, B8;
    logic [15:0] C8;
    logic        start16, sg16, busy16, done16;
    logic [15:0] A16, B16;
    logic [31:0] C16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
        .A(A8), .B(B8), .busy(busy8), .done(done8), .C(C8));

    seq_multiplier_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .is_signed(sg16),
        .A(A16), .B(B16), .busy(busy16), .done(done16), .C(C16));

    // Reference product: plain integer arithmetic reduced modulo 2^(2w).
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
        longint m  = (longint'(1) << w) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint p;
        if (s) begin
            if (ua >= (longint'(1) << (w - 1))) ua = ua - (longint'(1) << w);
            if (ub >= (longint'(1) << (w - 1))) ub = ub - (longint'(1) << w);
        end
        p = ua * ub;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        if (w == 8) begin
            start8 = st; A8 = a[7:0]; B8 = b[7:0]; sg8 = s;
        end else begin
            start16 = st; A16 = a[15:0]; B16 = b[15:0]; sg16 = s;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [63:0] get_c(input int w);
        return (w == 8) ? 64'(C8) : 64'(C16);
    endfunction

    // One operation: single-cycle start, operands scrambled while busy,
    // checks latency, busy length, product, single-cycle done and C hold.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input string tag);
        logic [63:0] exp;
        int k, busy_n;
        bit seen;
        exp = model(w, a, b, s);
        @(negedge clk);
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        drive(w, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
        k = 0; busy_n = 0; seen = 1'b0;
        while (!seen && k < 60) begin
            if (get_busy(w)) busy_n++;
            if (get_done(w)) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                k++;
                drive(w, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            end
        end
        chk({tag, "_latency"}, 64'(k), 64'(w + 1));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(w + 1));
        chk({tag, "_C"}, get_c(w), exp);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(get_done(w)), 64'd0);
        chk({tag, "_C_hold"}, get_c(w), exp);
    endtask

    initial begin
        int k, first, second;
        bit seen;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(16, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        chk("reset_busy", 64'(busy8), 64'd0);
        chk("reset_done", 64'(done8), 64'd0);
        chk("reset_C", 64'(C8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=8 cases
        op(8, 32'd239, 32'd35, 1'b0, "u239x35");
        op(8, 32'hEF, 32'd35, 1'b1, "s_m17x35");
        op(8, 32'h80, 32'h80, 1'b1, "s_min_sq");
        op(8, 32'h00, 32'h80, 1'b1, "s_zero");
        op(8, 32'd12, 32'd10, 1'b0, "stable");
        repeat (5) @(negedge clk);
        chk("stable_hold", 64'(C8), model(8, 32'd12, 32'd10, 1'b0));

        // Back-to-back with start held high
        @(negedge clk);
        drive(8, 1'b1, 32'd255, 32'd255, 1'b0);
        k = 0; first = -1; second = -1;
        while (second < 0 && k < 60) begin
            @(negedge clk);
            k++;
            if (done8) begin
                if (first < 0) begin
                    first = k;
                    chk("b2b_C1", 64'(C8), model(8, 32'd255, 32'd255, 1'b0));
                end else begin
                    second = k;
                    start8 = 1'b0;
                    chk("b2b_C2", 64'(C8), model(8, 32'd255, 32'd255, 1'b0));
                end
            end
        end
        start8 = 1'b0;
        chk("b2b_first", 64'(first), 64'd10);
        chk("b2b_period", 64'(second - first), 64'd10);

        // WIDTH=16 cases
        op(16, 32'hFFFF, 32'hFFFF, 1'b0, "w16_u_max");
        op(16, 32'h8000, 32'h0001, 1'b1, "w16_s_min");

        // Random operands on both widths
        for (int i = 0; i < 16; i++) begin
            ra = $urandom(); rb = $urandom();
            op(8, ra, rb, 1'($urandom_range(0, 1)), "rand8");
        end
        for (int i = 0; i < 6; i++) begin
            ra = $urandom(); rb = $urandom();
            op(16, ra, rb, 1'($urandom_range(0, 1)), "rand16");
        end

        // Mid-operation asynchronous reset at count=4
        repeat (2) @(negedge clk);
        drive(8, 1'b1, 32'd239, 32'd35, 1'b0);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_done", 64'(done8), 64'd0);
        chk("arst_C", 64'(C8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        chk("arst_no_done", 64'(seen), 64'd0);
        op(8, 32'd239, 32'd35, 1'b0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
